// File: rtl/tick_timer_ctrl.sv
// tick_timer_ctrl
//
// Programmable countdown timer built on a free-running prescaler.
// A countdown of Load_val ticks starts on Start. One Tick is produced
// every PERIOD clocks while running. Done pulses together with the
// final Tick. Pause freezes the prescaler. Abort cancels the countdown.
//
// Parameters
//   PERIOD   clock cycles per tick (>= 2)
//   CW       prescaler width, 2**CW >= PERIOD
//   NW       tick-count width
//
// Ports
//   CLK       in   clock, rising edge
//   Clr       in   synchronous active-high reset
//   Start     in   launch a countdown (sampled in IDLE only)
//   Load_val  in   tick count captured with Start
//   Pause     in   level, freezes the prescaler in RUN/HOLD
//   Abort     in   level, cancels the countdown
//   Tick      out  registered one-cycle pulse per prescaler wrap
//   Done      out  registered one-cycle pulse on completion
//   Busy      out  high in RUN or HOLD
//   Remain    out  registered count of ticks still to elapse
//   State     out  current state encoding (debug)

module tick_timer_ctrl #(
  parameter int PERIOD = 1000000,
  parameter int CW     = 20,
  parameter int NW     = 8
) (
  input  logic          CLK,
  input  logic          Clr,
  input  logic          Start,
  input  logic [NW-1:0] Load_val,
  input  logic          Pause,
  input  logic          Abort,
  output logic          Tick,
  output logic          Done,
  output logic          Busy,
  output logic [NW-1:0] Remain,
  output logic [1:0]    State
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [CW-1:0] A_LAST = CW'(PERIOD - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] a_q, a_d;
  logic [NW-1:0] remain_q, remain_d;
  logic          tick_q, tick_d;
  logic          done_q, done_d;

  // Next-state logic. Within RUN and HOLD the priority is
  // Abort > Pause > terminal count > increment; Tick and Done default
  // low so they are single-cycle pulses.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    remain_d = remain_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A zero-length countdown is ignored entirely.
        if (Start && (Load_val != '0)) begin
          state_d  = RUN;
          a_d      = '0;
          remain_d = Load_val;
        end
      end

      RUN: begin
        if (Abort) begin
          state_d  = IDLE;
          a_d      = '0;
          remain_d = '0;
        end else if (Pause) begin
          // Freeze the prescaler; a pending terminal count is deferred
          // until after resume.
          state_d = HOLD;
        end else if (a_q == A_LAST) begin
          a_d    = '0;
          tick_d = 1'b1;
          if (remain_q != '0) begin
            remain_d = remain_q - NW'(1);
          end
          if (remain_q == NW'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          a_d = a_q + CW'(1);
        end
      end

      HOLD: begin
        if (Abort) begin
          state_d  = IDLE;
          a_d      = '0;
          remain_d = '0;
        end else if (!Pause) begin
          // Resume edge does not count; counting restarts next edge.
          state_d = RUN;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single state register for FSM, prescaler and registered outputs.
  always_ff @(posedge CLK) begin
    if (Clr) begin
      state_q  <= IDLE;
      a_q      <= '0;
      remain_q <= '0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      remain_q <= remain_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

  assign Tick   = tick_q;
  assign Done   = done_q;
  assign Remain = remain_q;
  assign State  = state_q;
  assign Busy   = (state_q == RUN) || (state_q == HOLD);

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// tb_tick_timer_ctrl
//
// Bench for tick_timer_ctrl with PERIOD=4, NW=8. Directed scenarios
// followed by a randomized stretch, all compared every cycle against a
// reference model that tracks elapsed counting edges arithmetically.

module tb_tick_timer_ctrl;

  localparam int PERIOD = 4;
  localparam int CW     = 3;
  localparam int NW     = 8;

  logic          clk;
  logic          clr;
  logic          start;
  logic [NW-1:0] loadVal;
  logic          pause;
  logic          abort;
  logic          tick;
  logic          done;
  logic          busy;
  logic [NW-1:0] remain;
  logic [1:0]    state;

  int nVec;
  int nMis;
  int cycleNo;

  // Reference model: a countdown is "active" (RUN or HOLD) or
  // "finishing" (the DONE cycle). mProg counts the edges on which the
  // prescaler actually advanced; a tick is due whenever that count
  // reaches a multiple of PERIOD.
  bit mActive;
  bit mFinish;
  bit mHeld;
  int mProg;
  int mLoad;
  int mRemain;
  bit mTick;
  bit mDone;

  tick_timer_ctrl #(
    .PERIOD(PERIOD),
    .CW    (CW),
    .NW    (NW)
  ) dut (
    .CLK     (clk),
    .Clr     (clr),
    .Start   (start),
    .Load_val(loadVal),
    .Pause   (pause),
    .Abort   (abort),
    .Tick    (tick),
    .Done    (done),
    .Busy    (busy),
    .Remain  (remain),
    .State   (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance the model by one rising edge using the inputs sampled there.
  task automatic modelEdge();
    mTick = 1'b0;
    mDone = 1'b0;
    if (clr) begin
      mActive = 1'b0;
      mFinish = 1'b0;
      mHeld   = 1'b0;
      mProg   = 0;
      mRemain = 0;
    end else if (mFinish) begin
      mFinish = 1'b0;
    end else if (mActive) begin
      if (abort) begin
        mActive = 1'b0;
        mHeld   = 1'b0;
        mRemain = 0;
      end else if (pause) begin
        mHeld = 1'b1;
      end else if (mHeld) begin
        mHeld = 1'b0;
      end else begin
        mProg = mProg + 1;
        if ((mProg % PERIOD) == 0) begin
          mTick   = 1'b1;
          mRemain = mLoad - (mProg / PERIOD);
          if (mRemain == 0) begin
            mDone   = 1'b1;
            mActive = 1'b0;
            mFinish = 1'b1;
          end
        end
      end
    end else if (start && (loadVal != 0)) begin
      mActive = 1'b1;
      mHeld   = 1'b0;
      mProg   = 0;
      mLoad   = int'(loadVal);
      mRemain = int'(loadVal);
    end
  endtask

  function automatic int expState();
    if (mFinish) return 3;
    if (mActive) return mHeld ? 2 : 1;
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input int got, input int exp);
    nVec++;
    assert (got === exp)
    else begin
      nMis++;
      $error("[TB] FAIL %s cycle=%0d got=%0d exp=%0d", tag, cycleNo, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, then compare all outputs.
  task automatic applyStimulus(input logic s, input int lv, input logic p,
                               input logic a, input logic c);
    start   = s;
    loadVal = NW'(lv);
    pause   = p;
    abort   = a;
    clr     = c;
    @(posedge clk);
    modelEdge();
    cycleNo++;
    #1;
    checkOutput("tick",   int'(tick),   int'(mTick));
    checkOutput("done",   int'(done),   int'(mDone));
    checkOutput("busy",   int'(busy),   int'(mActive));
    checkOutput("remain", int'(remain), mRemain);
    checkOutput("state",  int'(state),  expState());
  endtask

  task automatic runQuiet(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    nVec    = 0;
    nMis    = 0;
    cycleNo = 0;
    mActive = 1'b0;
    mFinish = 1'b0;
    mHeld   = 1'b0;
    mProg   = 0;
    mLoad   = 0;
    mRemain = 0;
    start   = 1'b0;
    loadVal = '0;
    pause   = 1'b0;
    abort   = 1'b0;
    clr     = 1'b1;

    // Reset from power-up, then from mid-countdown
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 5, 1'b0, 1'b0, 1'b0);
    runQuiet(6);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 5, 1'b0, 1'b0, 1'b0);
    runQuiet(8);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    runQuiet(2);

    // Basic count of 3
    applyStimulus(1'b1, 3, 1'b0, 1'b0, 1'b0);
    runQuiet(15);

    // Pause over a terminal count
    applyStimulus(1'b1, 2, 1'b0, 1'b0, 1'b0);
    runQuiet(3);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
    runQuiet(12);

    // Abort at terminal count with one tick left, then abort from HOLD
    applyStimulus(1'b1, 5, 1'b0, 1'b0, 1'b0);
    runQuiet(19);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    runQuiet(3);
    applyStimulus(1'b1, 5, 1'b0, 1'b0, 1'b0);
    runQuiet(2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0);
    runQuiet(3);

    // Ignored inputs: zero load, Start during RUN, Start held through DONE
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(i[0], 7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2, 1'b0, 1'b0, 1'b0);
    runQuiet(10);

    // Maximum count
    applyStimulus(1'b1, 255, 1'b0, 1'b0, 1'b0);
    runQuiet(1024);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 6)),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 40) == 0),
                    ($urandom_range(0, 150) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/tick_timer_ctrl.md
# tick_timer_ctrl

Controller that sequences a free-running prescaler counter (the 1E6-cycle tick generator style used across this design) into a programmable countdown timer. It accepts a tick count, produces one `Tick` per `PERIOD` clocks, and supports pause/resume and abort. It pulses `Done` when the requested number of ticks has elapsed. It sits between user-level control (buttons/FSMs) and the prescaler datapath and owns that datapath exclusively.

## Interface
- `PERIOD`, 1000000: clock cycles per tick; must be ≥ 2.
- `CW`, 20: prescaler width; 2^CW ≥ `PERIOD`.
- `NW`, 8: tick-count width.

- `CLK` in 1: clock; all state changes on the rising edge.
- `Clr` in 1: reset, synchronous, active-high.
- `Start` in 1: sampled only in IDLE; launches a countdown of `Load_val` ticks.
- `Load_val` in NW: tick count, captured with `Start`.
- `Pause` in 1: level; while high in RUN or HOLD, the prescaler is frozen.
- `Abort` in 1: level; cancels the countdown and returns to IDLE.
- `Tick` out 1: registered; one-cycle pulse on each prescaler wrap.
- `Done` out 1: registered; one-cycle pulse when the countdown completes.
- `Busy` out 1: high in RUN or HOLD.
- `Remain` out NW: registered; ticks still to elapse.
- `State` out 2: current state encoding, for debug.

## Operation
- **States:**
  - IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10, DONE = 2'b11.
  - `Busy` is decoded from state only.
- **Internal prescaler:** `A[CW-1:0]`.
- **Priority per cycle:** `Clr` > `Abort` > `Pause` > terminal count > increment.
- **IDLE:**
  - `Start`=1 and `Load_val`≠0: go to RUN; `A`<=0; `Remain`<=`Load_val`.
  - `Start`=1 and `Load_val`=0: ignored; stay in IDLE with no `Done`.
  - `Pause` and `Abort` have no effect.
- **RUN:**
  - `Abort`: go to IDLE; `A`<=0; `Remain`<=0; no `Tick`, no `Done`.
  - Else `Pause`: go to HOLD; `A` holds; no `Tick`, even if `A`==`PERIOD`-1.
  - Else if `A`==`PERIOD`-1: `A`<=0; `Tick`<=1; `Remain`<=`Remain`-1.
    - If `Remain`==1, go to DONE and set `Done`<=1.
    - Otherwise stay in RUN.
  - Else: `A`<=`A`+1.
  - `Start` is ignored (no restart).
- **HOLD:**
  - `Abort`: go to IDLE (same clears as RUN).
  - Else `Pause`=0: go to RUN with `A` unchanged. Counting resumes on the following edge.
  - Else stay in HOLD.
- **DONE:**
  - Go to IDLE unconditionally on the next edge.
  - `Done` and `Tick` deassert there.
  - `Start`, `Pause` and `Abort` are ignored.
- **Output defaults:** `Tick` and `Done` are 0 in every cycle not listed above.
- **Arithmetic:** `Remain` never underflows; the decrement occurs only when `Remain`≥1. `A` never exceeds `PERIOD`-1.

## Timing
- **Reset values** (the cycle after an edge with `Clr`=1):
  - State = IDLE, `A`=0, `Remain`=0.
  - `Tick`=0, `Done`=0, `Busy`=0.
  - Takes effect from any state, including mid-countdown and mid-HOLD.
- **Start latency:** `Start` sampled at edge 0 gives RUN, `Busy`=1 and `A`=0 after edge 0.
- **Tick timing:** Tick k (k=1..`Load_val`) is high in the cycle after edge k·`PERIOD`, provided there is no pause.
- **Completion:**
  - The final tick and `Done` are high in the same cycle, after edge `Load_val`·`PERIOD`.
  - `Remain`=0 in that cycle.
  - State returns to IDLE one edge later.
- **Pause stretch:** each cycle spent in HOLD, plus the RUN→HOLD entry cycle, delays all later ticks by exactly one cycle each.
- **Restart:** earliest accepted `Start` is in the first IDLE cycle after DONE. Back-to-back countdowns therefore have a 1-cycle gap.
- **Simultaneous events:**
  - `Abort` with terminal count: abort wins; no `Tick`, no `Done`.
  - `Pause` with terminal count: pause wins; the tick fires after resume.

## Test plan
All scenarios use `PERIOD`=4 and `NW`=8.
1. **Reset:** assert `Clr` for 2 cycles from arbitrary state → all outputs 0, `State`=00; `Clr` mid-RUN with `Remain`=3 → IDLE next cycle, no `Done`.
2. **Basic count:** `Start` with `Load_val`=3 at edge 0 → `Tick` after edges 4, 8, 12; `Remain` 3→2→1→0; `Done` only after edge 12; `Busy` low after edge 13.
3. **Pause:** `Load_val`=2; `Pause` high for 5 cycles starting when `A`=3 → no tick that cycle; ticks shifted by 6 cycles; `Done` after edge 14.
4. **Abort:** `Load_val`=5; `Abort` at the cycle with `A`=3 and `Remain`=1 → IDLE, `Remain`=0, no `Tick`, no `Done`; also from HOLD.
5. **Ignored inputs:** `Start` with `Load_val`=0 → stays IDLE; `Start` pulses during RUN → countdown unaffected; `Start` held high through DONE → new run accepted exactly one cycle after the `Done` pulse.
6. **Max count:** `Load_val`=255 → 255 ticks; `Done` after edge 1020; `Remain` never wraps.
